// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Takes execute-stage results and either forwards the ALU value to writeback
// or runs a word/byte load or store against data memory over a req/ack
// handshake. A transaction that waits too long for its ack is aborted.
// Load data is lane-selected (big-endian) and sign/zero extended before it
// is registered onto the writeback / MX-bypass outputs.
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned DEST_W   = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   // upstream (execute) side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       alu_out,
   input  logic [31:0]       rb_out,
   input  logic              dmwe,
   input  logic              rwd,
   input  logic              dm_byte,
   input  logic              load_unsigned,
   input  logic              rwe,
   input  logic [DEST_W-1:0] rdest,
   // data memory side
   output logic              dm_req,
   output logic              dm_we,
   output logic [31:0]       dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [3:0]        dm_be,
   input  logic [31:0]       dm_rdata,
   input  logic              dm_ack,
   // writeback side
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic              wb_rwe,
   output logic [DEST_W-1:0] wb_rdest,
   output logic              mem_err
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   // The timeout compares against the last count before MAX_WAIT, so that a
   // request is held for exactly MAX_WAIT cycles when no ack arrives.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t              state_q, state_d;
   logic                dm_req_q, dm_req_d;
   logic                dm_we_q, dm_we_d;
   logic [31:0]         dm_addr_q, dm_addr_d;
   logic [31:0]         dm_wdata_q, dm_wdata_d;
   logic [3:0]          dm_be_q, dm_be_d;
   logic                wb_valid_q, wb_valid_d;
   logic [31:0]         wb_data_q, wb_data_d;
   logic                wb_rwe_q, wb_rwe_d;
   logic [DEST_W-1:0]   wb_rdest_q, wb_rdest_d;
   logic                mem_err_q, mem_err_d;
   logic [7:0]          wait_cnt_q, wait_cnt_d;

   // Attributes of the outstanding access needed only when it completes.
   logic                pend_byte_q, pend_byte_d;
   logic                pend_uns_q, pend_uns_d;
   logic [1:0]          pend_lane_q, pend_lane_d;
   logic                pend_rwe_q, pend_rwe_d;
   logic [DEST_W-1:0]   pend_rdest_q, pend_rdest_d;

   logic                accept;
   logic                is_mem;
   logic                misaligned;
   logic [3:0]          byte_be;
   logic [7:0]          lane_byte [4];
   logic [7:0]          load_byte;
   logic [31:0]         load_byte_ext;
   logic [31:0]         load_data;

   assign in_ready   = (state_q == S_IDLE);
   assign accept     = in_valid & in_ready;
   assign is_mem     = dmwe | rwd;
   assign misaligned = is_mem & ~dm_byte & (alu_out[1:0] != 2'b00);

   // Lane 0 is the most significant byte (big-endian lane numbering).
   assign byte_be = 4'b1000 >> alu_out[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_byte[gi] = dm_rdata[31-8*gi -: 8];
      end
   endgenerate

   assign load_byte     = lane_byte[pend_lane_q];
   assign load_byte_ext = pend_uns_q ? {24'h0, load_byte}
                                     : {{24{load_byte[7]}}, load_byte};
   assign load_data     = pend_byte_q ? load_byte_ext : dm_rdata;

   // Next-state and next-output logic for the IDLE/ACCESS controller.
   always_comb begin
      state_d      = state_q;
      dm_req_d     = dm_req_q;
      dm_we_d      = dm_we_q;
      dm_addr_d    = dm_addr_q;
      dm_wdata_d   = dm_wdata_q;
      dm_be_d      = dm_be_q;
      wb_valid_d   = 1'b0;
      wb_data_d    = wb_data_q;
      wb_rwe_d     = 1'b0;
      wb_rdest_d   = wb_rdest_q;
      mem_err_d    = 1'b0;
      wait_cnt_d   = wait_cnt_q;
      pend_byte_d  = pend_byte_q;
      pend_uns_d   = pend_uns_q;
      pend_lane_d  = pend_lane_q;
      pend_rwe_d   = pend_rwe_q;
      pend_rdest_d = pend_rdest_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  // Plain ALU result: straight through with one cycle latency.
                  wb_valid_d = 1'b1;
                  wb_data_d  = alu_out;
                  wb_rwe_d   = rwe;
                  wb_rdest_d = rdest;
               end else if (misaligned) begin
                  // Word access off a word boundary never reaches memory.
                  wb_valid_d = 1'b1;
                  mem_err_d  = 1'b1;
                  wb_rwe_d   = 1'b0;
                  wb_rdest_d = rdest;
               end else begin
                  state_d      = S_ACCESS;
                  dm_req_d     = 1'b1;
                  dm_we_d      = dmwe;
                  dm_addr_d    = {alu_out[31:2], 2'b00};
                  dm_be_d      = dm_byte ? byte_be : 4'b1111;
                  dm_wdata_d   = dm_byte ? {4{rb_out[7:0]}} : rb_out;
                  wait_cnt_d   = 8'd0;
                  pend_byte_d  = dm_byte;
                  pend_uns_d   = load_unsigned;
                  pend_lane_d  = alu_out[1:0];
                  // A store never writes the register file.
                  pend_rwe_d   = rwe & ~dmwe;
                  pend_rdest_d = rdest;
               end
            end
         end

         S_ACCESS: begin
            // Ack is tested first so it wins over a simultaneous timeout.
            if (dm_ack) begin
               state_d    = S_IDLE;
               dm_req_d   = 1'b0;
               dm_we_d    = 1'b0;
               wait_cnt_d = 8'd0;
               wb_valid_d = 1'b1;
               wb_rwe_d   = pend_rwe_q;
               wb_rdest_d = pend_rdest_q;
               if (!dm_we_q) begin
                  wb_data_d = load_data;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d    = S_IDLE;
               dm_req_d   = 1'b0;
               dm_we_d    = 1'b0;
               wait_cnt_d = 8'd0;
               wb_valid_d = 1'b1;
               mem_err_d  = 1'b1;
               wb_rwe_d   = 1'b0;
               wb_rdest_d = pend_rdest_q;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d  = S_IDLE;
            dm_req_d = 1'b0;
            dm_we_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any outstanding request at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         dm_req_q     <= 1'b0;
         dm_we_q      <= 1'b0;
         dm_addr_q    <= 32'h0;
         dm_wdata_q   <= 32'h0;
         dm_be_q      <= 4'h0;
         wb_valid_q   <= 1'b0;
         wb_data_q    <= 32'h0;
         wb_rwe_q     <= 1'b0;
         wb_rdest_q   <= '0;
         mem_err_q    <= 1'b0;
         wait_cnt_q   <= 8'd0;
         pend_byte_q  <= 1'b0;
         pend_uns_q   <= 1'b0;
         pend_lane_q  <= 2'b00;
         pend_rwe_q   <= 1'b0;
         pend_rdest_q <= '0;
      end else begin
         state_q      <= state_d;
         dm_req_q     <= dm_req_d;
         dm_we_q      <= dm_we_d;
         dm_addr_q    <= dm_addr_d;
         dm_wdata_q   <= dm_wdata_d;
         dm_be_q      <= dm_be_d;
         wb_valid_q   <= wb_valid_d;
         wb_data_q    <= wb_data_d;
         wb_rwe_q     <= wb_rwe_d;
         wb_rdest_q   <= wb_rdest_d;
         mem_err_q    <= mem_err_d;
         wait_cnt_q   <= wait_cnt_d;
         pend_byte_q  <= pend_byte_d;
         pend_uns_q   <= pend_uns_d;
         pend_lane_q  <= pend_lane_d;
         pend_rwe_q   <= pend_rwe_d;
         pend_rdest_q <= pend_rdest_d;
      end
   end

   assign dm_req   = dm_req_q;
   assign dm_we    = dm_we_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;
   assign dm_be    = dm_be_q;
   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rwe   = wb_rwe_q;
   assign wb_rdest = wb_rdest_q;
   assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized mix of ALU ops, loads, stores, misaligned words and timeouts,
// checked against a small arithmetic model of the memory-stage rules.
module tb_mem_access_stage;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_out, rb_out;
   logic        dmwe, rwd, dm_byte, load_unsigned, rwe;
   logic [4:0]  rdest;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic        wb_valid, wb_rwe, mem_err;
   logic [31:0] wb_data;
   logic [4:0]  wb_rdest;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mem_access_stage #(.MAX_WAIT(MW), .DEST_W(5)) dut (
      .clock(clk), .reset_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .rb_out(rb_out), .dmwe(dmwe), .rwd(rwd),
      .dm_byte(dm_byte), .load_unsigned(load_unsigned), .rwe(rwe), .rdest(rdest),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rwe(wb_rwe),
      .wb_rdest(wb_rdest), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (specification arithmetic) -----------
   function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic byt, input logic uns);
      logic [31:0] b;
      int k;
      if (!byt) return rdata;
      k = int'(addr % 4);
      b = (rdata >> (8 * (3 - k))) & 32'hFF;
      if (!uns && b >= 32'd128) b = b | 32'hFFFF_FF00;
      return b;
   endfunction

   function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic byt);
      int k;
      if (!byt) return 4'hF;
      k = int'(addr % 4);
      return 4'(1 << (3 - k));
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] data, input logic byt);
      if (!byt) return data;
      return (data & 32'hFF) * 32'h0101_0101;
   endfunction

   // ---------------- stimulus helpers (no comparisons inside) -------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; alu_out = 0; rb_out = 0; dmwe = 0; rwd = 0;
      dm_byte = 0; load_unsigned = 0; rwe = 0; rdest = 0;
   endtask

   // Present one instruction for a single accepting cycle.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic we,
                        input logic rd, input logic byt, input logic uns,
                        input logic rw, input logic [4:0] dst);
      alu_out = a; rb_out = b; dmwe = we; rwd = rd; dm_byte = byt;
      load_unsigned = uns; rwe = rw; rdest = dst; in_valid = 1;
      step();
      clear_inputs();
   endtask

   // Act as memory: ack in the ack_after-th request cycle (0 = never ack).
   task automatic serve(input int ack_after, input logic [31:0] rdata,
                        output int req_cycles, output int ready_low,
                        output logic [31:0] c_addr, output logic [31:0] c_wdata,
                        output logic [3:0] c_be, output logic c_we, output bit stable);
      req_cycles = 0; ready_low = 0; c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0;
      stable = 1;
      for (int i = 0; i < 64; i++) begin
         if (dm_req !== 1'b1) break;
         req_cycles++;
         if (in_ready !== 1'b1) ready_low++;
         if (req_cycles == 1) begin
            c_addr = dm_addr; c_wdata = dm_wdata; c_be = dm_be; c_we = dm_we;
         end else if (dm_addr !== c_addr || dm_wdata !== c_wdata ||
                      dm_be !== c_be || dm_we !== c_we) begin
            stable = 0;
         end
         if (req_cycles == ack_after) begin
            dm_ack = 1; dm_rdata = rdata;
         end
         step();
         dm_ack = 0; dm_rdata = $urandom;
      end
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      rst_n = 0; clear_inputs(); dm_ack = 0; dm_rdata = 0;
      step(); step();
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
      total_cnt++; if (dm_req !== 1'b0 || dm_we !== 1'b0) $display("FAIL reset_dm_ctl got req=%0b we=%0b exp=0", dm_req, dm_we); else pass_cnt++;
      total_cnt++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0 || dm_be !== 4'h0) $display("FAIL reset_dm_bus got addr=%08h wdata=%08h be=%0h exp=0", dm_addr, dm_wdata, dm_be); else pass_cnt++;
      total_cnt++; if (wb_valid !== 1'b0 || wb_rwe !== 1'b0 || mem_err !== 1'b0 || wb_data !== 32'h0 || wb_rdest !== 5'h0) $display("FAIL reset_wb got v=%0b rwe=%0b err=%0b data=%08h rd=%0d exp=0", wb_valid, wb_rwe, mem_err, wb_data, wb_rdest); else pass_cnt++;
      rst_n = 1;
      step();
      total_cnt++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) $display("FAIL reset_release got ready=%0b v=%0b exp ready=1 v=0", in_ready, wb_valid); else pass_cnt++;
      $display("reset: done");
   endtask

   task automatic test_alu_passthrough();
      issue(32'h1234_5678, 32'h0, 0, 0, 0, 0, 1, 5'd7);
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678 || wb_rdest !== 5'd7 || wb_rwe !== 1'b1) $display("FAIL alu_pass got v=%0b data=%08h rd=%0d rwe=%0b exp v=1 data=12345678 rd=7 rwe=1", wb_valid, wb_data, wb_rdest, wb_rwe); else pass_cnt++;
      total_cnt++; if (dm_req !== 1'b0 || mem_err !== 1'b0) $display("FAIL alu_no_req got req=%0b err=%0b exp 0", dm_req, mem_err); else pass_cnt++;
      step();
      total_cnt++; if (wb_valid !== 1'b0 || wb_data !== 32'h1234_5678) $display("FAIL alu_hold got v=%0b data=%08h exp v=0 data=12345678", wb_valid, wb_data); else pass_cnt++;
      $display("alu passthrough: data=%08h rd=%0d", wb_data, wb_rdest);
   endtask

   task automatic test_load(input logic [31:0] a, input logic uns, input int dly,
                            input logic [31:0] rdata, input string nm);
      int rc, rl; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st;
      logic [31:0] ew;
      ew = exp_load(a, rdata, 1'b1, uns);
      issue(a, 32'h0, 0, 1, 1, uns, 1, 5'd3);
      serve(dly, rdata, rc, rl, ca, cw, cb, cwe, st);
      total_cnt++; if (rc !== dly || rl !== dly) $display("FAIL %s_cycles got req=%0d stall=%0d exp %0d", nm, rc, rl, dly); else pass_cnt++;
      total_cnt++; if (ca !== (a & 32'hFFFF_FFFC) || cb !== exp_be(a, 1'b1) || cwe !== 1'b0 || !st) $display("FAIL %s_req got addr=%08h be=%04b we=%0b stable=%0b exp addr=%08h be=%04b we=0", nm, ca, cb, cwe, st, a & 32'hFFFF_FFFC, exp_be(a, 1'b1)); else pass_cnt++;
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== ew || wb_rwe !== 1'b1 || wb_rdest !== 5'd3) $display("FAIL %s_wb got v=%0b data=%08h rwe=%0b rd=%0d exp v=1 data=%08h rwe=1 rd=3", nm, wb_valid, wb_data, wb_rwe, wb_rdest, ew); else pass_cnt++;
      total_cnt++; if (dm_req !== 1'b0 || in_ready !== 1'b1 || mem_err !== 1'b0) $display("FAIL %s_done got req=%0b ready=%0b err=%0b exp 0/1/0", nm, dm_req, in_ready, mem_err); else pass_cnt++;
      $display("%s: addr=%08h rdata=%08h wb=%08h", nm, a, rdata, wb_data);
   endtask

   task automatic test_sb();
      int rc, rl; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st;
      issue(32'h201, 32'hAABB_CCDD, 1, 0, 1, 0, 1, 5'd9);
      serve(2, 32'h0, rc, rl, ca, cw, cb, cwe, st);
      total_cnt++; if (cwe !== 1'b1 || cb !== 4'b0100 || ca !== 32'h200 || cw !== 32'hDDDD_DDDD || !st) $display("FAIL sb_req got we=%0b be=%04b addr=%08h wdata=%08h stable=%0b exp we=1 be=0100 addr=00000200 wdata=dddddddd", cwe, cb, ca, cw, st); else pass_cnt++;
      total_cnt++; if (wb_valid !== 1'b1 || wb_rwe !== 1'b0 || mem_err !== 1'b0) $display("FAIL sb_wb got v=%0b rwe=%0b err=%0b exp v=1 rwe=0 err=0", wb_valid, wb_rwe, mem_err); else pass_cnt++;
      $display("sb: addr=%08h be=%04b wdata=%08h", ca, cb, cw);
   endtask

   task automatic test_misaligned();
      issue(32'h102, 32'h0, 0, 1, 0, 0, 1, 5'd4);
      total_cnt++; if (dm_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_rwe !== 1'b0 || in_ready !== 1'b1) $display("FAIL misaligned got req=%0b err=%0b v=%0b rwe=%0b ready=%0b exp 0/1/1/0/1", dm_req, mem_err, wb_valid, wb_rwe, in_ready); else pass_cnt++;
      step();
      total_cnt++; if (mem_err !== 1'b0 || wb_valid !== 1'b0 || dm_req !== 1'b0) $display("FAIL misaligned_pulse got err=%0b v=%0b req=%0b exp 0", mem_err, wb_valid, dm_req); else pass_cnt++;
      $display("misaligned lw: addr=00000102 err pulse seen");
   endtask

   task automatic test_timeout();
      int rc, rl; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st;
      issue(32'h300, 32'h0, 0, 1, 0, 0, 1, 5'd6);
      serve(0, 32'h0, rc, rl, ca, cw, cb, cwe, st);
      total_cnt++; if (rc !== MW) $display("FAIL timeout_req_cycles got=%0d exp=%0d", rc, MW); else pass_cnt++;
      total_cnt++; if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_rwe !== 1'b0 || in_ready !== 1'b1 || dm_req !== 1'b0) $display("FAIL timeout_abort got err=%0b v=%0b rwe=%0b ready=%0b req=%0b exp 1/1/0/1/0", mem_err, wb_valid, wb_rwe, in_ready, dm_req); else pass_cnt++;
      step();
      total_cnt++; if (mem_err !== 1'b0 || wb_valid !== 1'b0) $display("FAIL timeout_pulse got err=%0b v=%0b exp 0", mem_err, wb_valid); else pass_cnt++;
      $display("timeout: req held %0d cycles", rc);
   endtask

   task automatic test_ack_at_limit();
      int rc, rl; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st;
      issue(32'h400, 32'h0, 0, 1, 0, 0, 1, 5'd8);
      serve(MW, 32'hCAFE_F00D, rc, rl, ca, cw, cb, cwe, st);
      total_cnt++; if (rc !== MW || mem_err !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || wb_rwe !== 1'b1) $display("FAIL ack_at_limit got cyc=%0d err=%0b v=%0b data=%08h rwe=%0b exp cyc=%0d err=0 v=1 data=cafef00d rwe=1", rc, mem_err, wb_valid, wb_data, wb_rwe, MW); else pass_cnt++;
      $display("ack at limit: wb=%08h", wb_data);
   endtask

   task automatic test_reset_mid_access();
      bit stray_wb;
      issue(32'h500, 32'h0, 0, 1, 0, 0, 1, 5'd2);
      total_cnt++; if (dm_req !== 1'b1) $display("FAIL rst_mid_req_up got=%0b exp=1", dm_req); else pass_cnt++;
      #2 rst_n = 0;
      #1;
      total_cnt++; if (dm_req !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid_drop got req=%0b ready=%0b exp 0/1", dm_req, in_ready); else pass_cnt++;
      step();
      rst_n = 1;
      stray_wb = 0;
      dm_ack = 1; dm_rdata = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         step();
         if (wb_valid !== 1'b0 || dm_req !== 1'b0) stray_wb = 1;
      end
      dm_ack = 0;
      total_cnt++; if (stray_wb) $display("FAIL rst_stray_ack got a wb_valid/dm_req after release exp none"); else pass_cnt++;
      $display("reset mid access: request dropped, stray ack ignored");
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [5];
      int bad;
      bad = 0;
      for (int i = 0; i < 5; i++) vals[i] = $urandom;
      for (int i = 0; i < 5; i++) begin
         alu_out = vals[i]; rdest = 5'(i + 10); rwe = 1; dmwe = 0; rwd = 0; in_valid = 1;
         step();
         total_cnt++; if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_rdest !== 5'(i + 10) || in_ready !== 1'b1) begin
            $display("FAIL b2b_%0d got v=%0b data=%08h rd=%0d exp v=1 data=%08h rd=%0d", i, wb_valid, wb_data, wb_rdest, vals[i], i + 10);
            bad++;
         end else pass_cnt++;
      end
      clear_inputs();
      step();
      $display("back to back: 5 alu ops, %0d bad", bad);
   endtask

   task automatic test_random();
      int rc, rl; logic [31:0] ca, cw; logic [3:0] cb; logic cwe; bit st;
      for (int n = 0; n < 40; n++) begin
         int kind, dly, exp_cyc;
         logic [31:0] a, b, rd_data, ew;
         logic byt, uns, rw;
         logic [4:0] dst;
         kind = $urandom_range(0, 3);
         a = $urandom; b = $urandom; rd_data = $urandom;
         byt = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1)); dst = 5'($urandom);
         dly = $urandom_range(0, 3);
         if (kind == 0) begin
            issue(a, b, 0, 0, byt, uns, rw, dst);
            total_cnt++; if (wb_valid !== 1'b1 || wb_data !== a || wb_rwe !== rw || wb_rdest !== dst || dm_req !== 1'b0) $display("FAIL rnd%0d_alu got v=%0b data=%08h rwe=%0b rd=%0d exp data=%08h rwe=%0b rd=%0d", n, wb_valid, wb_data, wb_rwe, wb_rdest, a, rw, dst); else pass_cnt++;
            $display("rnd%0d alu a=%08h", n, a);
         end else if (kind == 3) begin
            if (a[1:0] == 2'b00) a = a | 32'h1;
            issue(a, b, 1'($urandom_range(0, 1)), 1, 0, uns, rw, dst);
            total_cnt++; if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_rwe !== 1'b0 || dm_req !== 1'b0) $display("FAIL rnd%0d_misal got err=%0b v=%0b rwe=%0b req=%0b exp 1/1/0/0", n, mem_err, wb_valid, wb_rwe, dm_req); else pass_cnt++;
            $display("rnd%0d misaligned a=%08h", n, a);
         end else begin
            logic is_st;
            is_st = (kind == 2);
            if (!byt) a = a & 32'hFFFF_FFFC;
            issue(a, b, is_st, !is_st, byt, uns, rw, dst);
            serve(dly, rd_data, rc, rl, ca, cw, cb, cwe, st);
            exp_cyc = (dly == 0) ? MW : dly;
            total_cnt++; if (rc !== exp_cyc || ca !== (a & 32'hFFFF_FFFC) || cb !== exp_be(a, byt) || cwe !== is_st || !st || (is_st && cw !== exp_wdata(b, byt))) $display("FAIL rnd%0d_req got cyc=%0d addr=%08h be=%04b we=%0b wdata=%08h exp cyc=%0d addr=%08h be=%04b we=%0b wdata=%08h", n, rc, ca, cb, cwe, cw, exp_cyc, a & 32'hFFFF_FFFC, exp_be(a, byt), is_st, exp_wdata(b, byt)); else pass_cnt++;
            if (dly == 0) begin
               total_cnt++; if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_rwe !== 1'b0) $display("FAIL rnd%0d_tmo got err=%0b v=%0b rwe=%0b exp 1/1/0", n, mem_err, wb_valid, wb_rwe); else pass_cnt++;
            end else if (is_st) begin
               total_cnt++; if (mem_err !== 1'b0 || wb_valid !== 1'b1 || wb_rwe !== 1'b0) $display("FAIL rnd%0d_st got err=%0b v=%0b rwe=%0b exp 0/1/0", n, mem_err, wb_valid, wb_rwe); else pass_cnt++;
            end else begin
               ew = exp_load(a, rd_data, byt, uns);
               total_cnt++; if (mem_err !== 1'b0 || wb_valid !== 1'b1 || wb_data !== ew || wb_rwe !== rw || wb_rdest !== dst) $display("FAIL rnd%0d_ld got err=%0b v=%0b data=%08h rwe=%0b rd=%0d exp data=%08h rwe=%0b rd=%0d", n, mem_err, wb_valid, wb_data, wb_rwe, wb_rdest, ew, rw, dst); else pass_cnt++;
            end
            $display("rnd%0d %s byte=%0b a=%08h dly=%0d", n, is_st ? "store" : "load", byt, a, dly);
         end
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_load(32'h100, 1'b0, 3, 32'h80FF_0102, "lb_sext");
      test_load(32'h103, 1'b1, 1, 32'h0000_00F0, "lbu_off3");
      test_sb();
      test_misaligned();
      test_timeout();
      test_ack_at_limit();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage unit on the consuming side of the execute outputs: ALU result, store data, dmwe, dm_byte, rwe, rwd.
- Performs word or byte loads and stores against data memory over a req/ack handshake, with a wait-state timeout.
- Formats load data (byte select, sign or zero extension) and presents registered writeback and MX-bypass results.
- Stalls the upstream execute stage while a memory transaction is outstanding.

Parameters:
- MAX_WAIT, 16, cycles dm_req may stay unacknowledged before abort; 1..255.
- DEST_W, 5, register-destination index width.

Ports:
- clock  input  1  single clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  execute result valid this cycle.
- in_ready  output  1  stage can accept; low = stall execute.
- alu_out  input  32  ALU result: memory address for loads/stores, result otherwise.
- rb_out  input  32  store data.
- dmwe  input  1  store.
- rwd  input  1  load: writeback takes memory data.
- dm_byte  input  1  byte access (LB/LBU/SB).
- load_unsigned  input  1  zero-extend byte load (LBU).
- rwe  input  1  instruction writes register file.
- rdest  input  DEST_W  destination register index.
- dm_req  output  1  memory request; held until dm_ack.
- dm_we  output  1  write request.
- dm_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- dm_wdata  output  32  write data.
- dm_be  output  4  byte enables, bit3 = bits[31:24].
- dm_rdata  input  32  read data, valid with dm_ack.
- dm_ack  input  1  transaction complete.
- wb_valid  output  1  one-cycle pulse: result ready for writeback.
- wb_data  output  32  writeback / MX-bypass value.
- wb_rwe  output  1  registered rwe; 0 when wb_valid=0 or on error.
- wb_rdest  output  DEST_W  registered rdest.
- mem_err  output  1  one-cycle pulse: misaligned word access or timeout.

Behaviour:
- Reset (asynchronous): state IDLE. in_ready=1. dm_req, dm_we, wb_valid, wb_rwe, mem_err all 0. dm_addr, dm_wdata, wb_data all 0. dm_be=0, wb_rdest=0, wait counter=0.
- Reset during ACCESS drops dm_req immediately. A late dm_ack after release is ignored.
- FSM states: IDLE, ACCESS.
  - IDLE, accept (in_valid & in_ready):
    - If neither dmwe nor rwd is set: next cycle wb_valid=1, wb_data=alu_out, wb_rwe=rwe, wb_rdest=rdest. Latency 1; back-to-back accepts allowed.
    - If dmwe or rwd is set and the access is a word access with alu_out[1:0]!=0: no request; next cycle mem_err=1, wb_valid=1, wb_rwe=0.
    - Otherwise enter ACCESS. dm_req=1 next cycle; in_ready=0 from that cycle.
  - ACCESS: dm_req, dm_we, dm_addr, dm_wdata, dm_be held stable until dm_ack. The wait counter increments each cycle with no ack.
    - On dm_ack: dm_req=0 the next cycle, wb_valid=1 next cycle, return to IDLE, in_ready=1 next cycle.
    - When the counter reaches MAX_WAIT with no ack: drop dm_req, mem_err=1 and wb_valid=1 with wb_rwe=0 next cycle, return to IDLE.
    - dm_ack in the same cycle as the counter reaching MAX_WAIT: the ack wins.
- Byte lanes are big-endian. Lane k = alu_out[1:0]; dm_be = 4'b1000 >> k.
  - Store byte: dm_wdata = {4{rb_out[7:0]}}.
  - Store word: dm_be=4'b1111, dm_wdata=rb_out.
  - Load byte: byte = dm_rdata[31-8k -: 8]. Sign-extend unless load_unsigned=1, then zero-extend.
  - Load word: dm_be=4'b1111, wb_data=dm_rdata.
  - Stores: wb_valid pulses on completion, wb_rwe=0.
- dm_we=dmwe, registered at accept. Loads have dm_we=0.
- in_valid while in_ready=0 is not accepted. Upstream holds its inputs.
- wb_data holds its last value when wb_valid=0.

Test Plan:
- ALU passthrough: alu_out=0x1234_5678, rwe=1, rdest=7, dmwe=rwd=0 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rdest=7, no dm_req.
- LB sign-extend: alu_out=0x100, dm_byte=1, rwd=1, ack after 3 cycles with dm_rdata=0x80FF_0102 -> dm_be=4'b1000, dm_addr=0x100, in_ready low 3 cycles, wb_data=0xFFFF_FF80.
- LBU at offset 3: alu_out=0x103, load_unsigned=1, dm_rdata=0x0000_00F0 -> dm_be=4'b0001, dm_addr=0x100, wb_data=0x0000_00F0.
- SB at 0x201, rb_out=0xAABB_CCDD -> dm_we=1, dm_be=4'b0100, dm_addr=0x200, dm_wdata=0xDDDD_DDDD, wb_rwe=0.
- Misaligned LW at 0x102 -> no dm_req, mem_err pulse, wb_rwe=0. Also: MAX_WAIT=4, never ack -> dm_req high 4 cycles then dropped, mem_err pulse, in_ready returns 1.
- reset_n low mid-ACCESS -> dm_req=0 immediately. After release, a stray dm_ack produces no wb_valid.
